// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Operand/result bundle between the multicycle control path and the
// multiply/divide unit.
//   start    : one-cycle request from the control unit
//   op       : 0 = MULT, 1 = DIV (valid with start)
//   src_a    : multiplicand / dividend (signed)
//   src_b    : multiplier / divisor (signed)
//   hi, lo   : result words for the HI/LO registers
//   busy     : unit is not idle
//   done     : one-cycle pulse, hi/lo valid
//   div_zero : one-cycle pulse, DIV by zero requested
// master = control unit side, slave = the arithmetic unit.
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output start, op, src_a, src_b,
      input  hi, lo, busy, done, div_zero
   );

   modport slave (
      input  start, op, src_a, src_b,
      output hi, lo, busy, done, div_zero
   );
endinterface

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Sequential signed multiply (radix-2 Booth) and divide (restoring on
// magnitudes with a sign fixup cycle) for the multicycle MIPS datapath.
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   mdBus  : mult_div_unit_if.slave (start/op/src_a/src_b in,
//            hi/lo/busy/done/div_zero out)
// Optional build macro MD_EARLY_OUT_EN: MULT with a zero operand and DIV with
// |src_a| < |src_b| finish straight from IDLE without iterating.
// done and div_zero are registered from the DONE/DZ states, so each pulse
// appears in the cycle after the FSM passes through that state.
// ---------------------------------------------------------------------------
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic           clock,
   input  logic           reset,
   mult_div_unit_if.slave mdBus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE, DZ} state_t;

   state_t                  state;
   // One extra accumulator bit keeps A-M exact when M is the most negative value.
   logic signed [WIDTH:0]   accA;
   logic [WIDTH-1:0]        regQ;
   logic                    qMinus1;
   logic [WIDTH-1:0]        regM;
   logic [WIDTH-1:0]        remR;
   logic [WIDTH-1:0]        magB;
   logic                    negA;
   logic                    negB;
   logic [CNT_W-1:0]        count;
   logic [WIDTH-1:0]        hiReg;
   logic [WIDTH-1:0]        loReg;
   logic                    busyReg;
   logic                    doneReg;
   logic                    dzReg;

   logic [WIDTH-1:0]        absA;
   logic [WIDTH-1:0]        absB;
   logic signed [WIDTH:0]   mExt;
   logic signed [WIDTH:0]   boothSum;
   logic signed [WIDTH:0]   boothA;
   logic [WIDTH-1:0]        boothQ;
   logic [WIDTH:0]          divShift;
   logic [WIDTH-1:0]        divDiff;
   logic [WIDTH-1:0]        nextR;
   logic [WIDTH-1:0]        nextQ;
   logic [WIDTH-1:0]        fixQuot;
   logic [WIDTH-1:0]        fixRem;

   // Magnitudes are unsigned, so |-2^(WIDTH-1)| is representable.
   assign absA = mdBus.src_a[WIDTH-1] ? -mdBus.src_a : mdBus.src_a;
   assign absB = mdBus.src_b[WIDTH-1] ? -mdBus.src_b : mdBus.src_b;

   // Booth step: add/subtract M per {Q[0],Q-1}, then arithmetic shift right.
   always_comb begin
      mExt     = $signed({regM[WIDTH-1], regM});
      boothSum = accA;
      case ({regQ[0], qMinus1})
         2'b01:   boothSum = accA + mExt;
         2'b10:   boothSum = accA - mExt;
         default: boothSum = accA;
      endcase
      boothA = {boothSum[WIDTH], boothSum[WIDTH:1]};
      boothQ = {boothSum[0], regQ[WIDTH-1:1]};
   end

   // Restoring step: the partial remainder always stays below |b|, so the
   // difference fits in WIDTH bits whenever the trial succeeds.
   always_comb begin
      divShift = {remR, regQ[WIDTH-1]};
      divDiff  = divShift[WIDTH-1:0] - magB;
      if (divShift >= {1'b0, magB}) begin
         nextR = divDiff;
         nextQ = {regQ[WIDTH-2:0], 1'b1};
      end else begin
         nextR = divShift[WIDTH-1:0];
         nextQ = {regQ[WIDTH-2:0], 1'b0};
      end
      fixQuot = (negA ^ negB) ? -regQ : regQ;
      fixRem  = negA ? -remR : remR;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         accA    <= '0;
         regQ    <= '0;
         qMinus1 <= 1'b0;
         regM    <= '0;
         remR    <= '0;
         magB    <= '0;
         negA    <= 1'b0;
         negB    <= 1'b0;
         count   <= '0;
         hiReg   <= '0;
         loReg   <= '0;
         busyReg <= 1'b0;
         doneReg <= 1'b0;
         dzReg   <= 1'b0;
      end else begin
         doneReg <= (state == DONE);
         dzReg   <= (state == DZ);
         case (state)
            IDLE: begin
               if (mdBus.start) begin
                  busyReg <= 1'b1;
                  if (!mdBus.op) begin
`ifdef MD_EARLY_OUT_EN
                     if ((mdBus.src_a == '0) || (mdBus.src_b == '0)) begin
                        hiReg <= '0;
                        loReg <= '0;
                        state <= DONE;
                     end else begin
                        accA    <= '0;
                        regQ    <= mdBus.src_a;
                        qMinus1 <= 1'b0;
                        regM    <= mdBus.src_b;
                        count   <= '0;
                        state   <= MULT;
                     end
`else
                     accA    <= '0;
                     regQ    <= mdBus.src_a;
                     qMinus1 <= 1'b0;
                     regM    <= mdBus.src_b;
                     count   <= '0;
                     state   <= MULT;
`endif
                  end else if (mdBus.src_b == '0) begin
                     state <= DZ;
                  end else begin
`ifdef MD_EARLY_OUT_EN
                     if (absA < absB) begin
                        hiReg <= mdBus.src_a;
                        loReg <= '0;
                        state <= DONE;
                     end else begin
                        negA  <= mdBus.src_a[WIDTH-1];
                        negB  <= mdBus.src_b[WIDTH-1];
                        regQ  <= absA;
                        magB  <= absB;
                        remR  <= '0;
                        count <= '0;
                        state <= DIV;
                     end
`else
                     negA  <= mdBus.src_a[WIDTH-1];
                     negB  <= mdBus.src_b[WIDTH-1];
                     regQ  <= absA;
                     magB  <= absB;
                     remR  <= '0;
                     count <= '0;
                     state <= DIV;
`endif
                  end
               end
            end
            MULT: begin
               accA    <= boothA;
               regQ    <= boothQ;
               qMinus1 <= regQ[0];
               count   <= count + 1'b1;
               if (count == LAST_STEP) begin
                  hiReg <= boothA[WIDTH-1:0];
                  loReg <= boothQ;
                  state <= DONE;
               end
            end
            DIV: begin
               remR  <= nextR;
               regQ  <= nextQ;
               count <= count + 1'b1;
               if (count == LAST_STEP) begin
                  state <= FIX;
               end
            end
            FIX: begin
               hiReg <= fixRem;
               loReg <= fixQuot;
               state <= DONE;
            end
            DONE: begin
               busyReg <= 1'b0;
               state   <= IDLE;
            end
            DZ: begin
               busyReg <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               busyReg <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign mdBus.hi       = hiReg;
   assign mdBus.lo       = loReg;
   assign mdBus.busy     = busyReg;
   assign mdBus.done     = doneReg;
   assign mdBus.div_zero = dzReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit: directed cases plus randomized
// MULT/DIV operations compared against 64-bit integer arithmetic.
// Honours MD_EARLY_OUT_EN for expected latencies.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
   localparam int W = 32;

   logic clock = 1'b0;
   logic reset;

   mult_div_unit_if #(.WIDTH(W)) mdBus ();

   mult_div_unit #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .mdBus (mdBus.slave)
   );

   always #5 clock = ~clock;

   int vecCount = 0;
   int errCount = 0;
   logic [W-1:0] prevHi = '0;
   logic [W-1:0] prevLo = '0;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vecCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic longint absVal(input logic [W-1:0] v);
      longint s;
      s = longint'($signed(v));
      return (s < 0) ? -s : s;
   endfunction

   // Edges after the start edge until the done (or div_zero) pulse is visible.
   function automatic int expLat(input logic opSel, input logic [W-1:0] a, input logic [W-1:0] b);
      if (opSel && b == '0) return 1;
`ifdef MD_EARLY_OUT_EN
      if (!opSel && (a == '0 || b == '0)) return 1;
      if (opSel && absVal(a) < absVal(b)) return 1;
`endif
      return opSel ? 34 : 33;
   endfunction

   task automatic doOp(input logic opSel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int ignoreAt);
      longint sa, sb;
      logic [63:0] res;
      logic [W-1:0] eHi, eLo;
      int lat, doneCnt, firstDone, dzCnt, firstDz;
      bit busyOk, holdOk, isDz;
      string nm;

      sa = longint'($signed(a));
      sb = longint'($signed(b));
      isDz = opSel && (b == '0);
      if (!opSel) begin
         res = sa * sb;
         eHi = res[63:32];
         eLo = res[31:0];
      end else if (!isDz) begin
         res = sa / sb;
         eLo = res[31:0];
         res = sa % sb;
         eHi = res[31:0];
      end else begin
         eHi = prevHi;
         eLo = prevLo;
      end
      lat = expLat(opSel, a, b);
      nm = $sformatf("%s %h,%h", opSel ? "div" : "mul", a, b);

      @(negedge clock);
      mdBus.start = 1'b1;
      mdBus.op    = opSel;
      mdBus.src_a = a;
      mdBus.src_b = b;
      @(posedge clock);
      #1;
      mdBus.start = 1'b0;
      mdBus.op    = 1'($urandom);
      mdBus.src_a = $urandom;
      mdBus.src_b = $urandom;

      doneCnt = 0; firstDone = -1; dzCnt = 0; firstDz = -1;
      busyOk = 1'b1; holdOk = 1'b1;
      for (int k = 1; k <= lat + 3; k++) begin
         @(posedge clock);
         #1;
         if (mdBus.done) begin
            doneCnt++;
            if (firstDone < 0) firstDone = k;
         end
         if (mdBus.div_zero) begin
            dzCnt++;
            if (firstDz < 0) firstDz = k;
         end
         if (mdBus.busy !== (k < lat)) busyOk = 1'b0;
         if ((isDz || k < lat - 1) && (mdBus.hi !== prevHi || mdBus.lo !== prevLo))
            holdOk = 1'b0;
         if (k == ignoreAt) begin
            mdBus.start = 1'b1;
            mdBus.op    = 1'b1;
            mdBus.src_a = $urandom;
            mdBus.src_b = '0;
         end
         if (k == ignoreAt + 1) mdBus.start = 1'b0;
      end

      if (isDz) begin
         checkVal({nm, " dz edge"}, 64'(firstDz), 64'(1));
         checkVal({nm, " dz count"}, 64'(dzCnt), 64'(1));
         checkVal({nm, " done count"}, 64'(doneCnt), 64'(0));
      end else begin
         checkVal({nm, " done edge"}, 64'(firstDone), 64'(lat));
         checkVal({nm, " done count"}, 64'(doneCnt), 64'(1));
         checkVal({nm, " dz count"}, 64'(dzCnt), 64'(0));
      end
      checkVal({nm, " busy"}, 64'(busyOk), 64'(1));
      checkVal({nm, " hold"}, 64'(holdOk), 64'(1));
      checkVal({nm, " hi"}, 64'(mdBus.hi), 64'(eHi));
      checkVal({nm, " lo"}, 64'(mdBus.lo), 64'(eLo));
      checkVal({nm, " idle after"}, 64'(mdBus.busy), 64'(0));
      prevHi = eHi;
      prevLo = eLo;
   endtask

   task automatic resetMidMult();
      int doneCnt;
      @(negedge clock);
      mdBus.start = 1'b1;
      mdBus.op    = 1'b0;
      mdBus.src_a = 32'h0001_2345;
      mdBus.src_b = 32'h0000_0777;
      @(posedge clock);
      #1;
      mdBus.start = 1'b0;
      repeat (15) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      checkVal("reset busy", 64'(mdBus.busy), 64'(0));
      checkVal("reset hi", 64'(mdBus.hi), 64'(0));
      checkVal("reset lo", 64'(mdBus.lo), 64'(0));
      checkVal("reset done", 64'(mdBus.done), 64'(0));
      reset = 1'b0;
      doneCnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock);
         #1;
         if (mdBus.done || mdBus.busy) doneCnt++;
      end
      checkVal("reset aborts op", 64'(doneCnt), 64'(0));
      prevHi = '0;
      prevLo = '0;
   endtask

   function automatic logic [W-1:0] pickVal();
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return W'($urandom_range(0, 15));
         4:       return -W'($urandom_range(1, 15));
         5:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      mdBus.start = 1'b0;
      mdBus.op    = 1'b0;
      mdBus.src_a = '0;
      mdBus.src_b = '0;
      repeat (3) @(posedge clock);
      #1;
      checkVal("init hi", 64'(mdBus.hi), 64'(0));
      checkVal("init lo", 64'(mdBus.lo), 64'(0));
      checkVal("init busy", 64'(mdBus.busy), 64'(0));
      checkVal("init done", 64'(mdBus.done), 64'(0));
      checkVal("init div_zero", 64'(mdBus.div_zero), 64'(0));
      @(negedge clock);
      reset = 1'b0;

      doOp(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, -5);
      doOp(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, -5);
      doOp(1'b1, 32'h0000_0064, 32'h0000_0000, -5);
      doOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -5);
      doOp(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 10);
      doOp(1'b0, 32'h0000_1234, 32'h0000_5678, 32);
      doOp(1'b0, 32'h0000_0005, 32'h0000_0000, -5);
      doOp(1'b0, 32'h8000_0000, 32'h8000_0000, -5);
      doOp(1'b1, 32'h0000_0003, 32'hFFFF_FFF9, -5);
      resetMidMult();

      for (int n = 0; n < 40; n++) begin
         logic          rOp;
         logic [W-1:0]  rA, rB;
         rOp = 1'($urandom_range(0, 1));
         rA  = pickVal();
         rB  = pickVal();
         doOp(rOp, rA, rB, -5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential signed multiply/divide unit for the multicycle MIPS datapath.
- Sits downstream of the MDSrcA/MDSrcB operand muxes and upstream of the HI/LO registers.
- The control unit pulses start with an op select, waits for done, then writes hi/lo into HI/LO.
- Implements MULT (radix-2 Booth) and DIV (restoring, signed fixup) with MIPS semantics.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  1  0 = MULT, 1 = DIV; sampled with start
- src_a  input  WIDTH  multiplicand / dividend (signed)
- src_b  input  WIDTH  multiplier / divisor (signed)
- hi  output  WIDTH  MULT: upper product word; DIV: remainder
- lo  output  WIDTH  MULT: lower product word; DIV: quotient
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when hi/lo become valid
- div_zero  output  1  one-cycle pulse; DIV requested with src_b == 0

Behaviour:
- Reset and clocking:
  - One clock domain; reset is synchronous and active-high.
  - Reset forces state IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; internal counter and accumulators cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, MULT, DIV, FIX, DONE, DZ.
- IDLE:
  - start=1, op=0 -> MULT; load A=0, Q=src_a, Q-1=0, M=src_b, count=0.
  - start=1, op=1, src_b!=0 -> DIV; latch operand signs, load magnitudes, remainder=0, count=0.
  - start=1, op=1, src_b==0 -> DZ.
  - start=0 -> stay in IDLE.
- MULT:
  - One Booth step per cycle: examine {Q[0],Q-1}; 01 -> A+=M, 10 -> A-=M; then arithmetic shift right {A,Q,Q-1}.
  - After the 32nd step (count==WIDTH-1) -> DONE.
  - hi=A, lo=Q are latched on that edge.
- DIV:
  - One restoring step per cycle on magnitudes: shift {R,Q} left 1; trial R-|b|; if non-negative keep it and set Q[0]=1.
  - After 32 steps -> FIX.
- FIX (1 cycle):
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Latch hi=remainder, lo=quotient; -> DONE.
  - Overflow case -2^31 / -1: lo=0x80000000, hi=0 (wraps, no flag).
- DONE: done=1 for exactly one cycle -> IDLE.
- DZ: div_zero=1 for one cycle, done stays 0, hi/lo unchanged -> IDLE.
- Latency (start sampled at edge 0):
  - MULT: done high in the cycle after edge 33.
  - DIV: done high in the cycle after edge 34.
  - div_zero: high in the cycle after edge 1.
- hi/lo hold their value until the next completed operation; they are never updated during iterations.
- start while busy is ignored; no queuing and no effect on the running operation.
- Operands are captured at start; src_a/src_b may change freely afterwards.
- start asserted in the DONE cycle is ignored; a new start is accepted from the IDLE cycle onward.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined:
  - MULT with src_a==0 or src_b==0 skips iteration: IDLE -> DONE with hi=lo=0 latched; done appears in the cycle after edge 1.
  - DIV with |src_a| < |src_b| skips iteration: IDLE -> DONE with lo=0, hi=src_a; same timing.
- Undefined: every MULT/DIV takes the full latency above.

Test Plan:
- MULT 7 x -3 (src_a=0x00000007, src_b=0xFFFFFFFD) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulse 33 cycles after start; busy high throughout.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002) -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); done 34 cycles after start.
- DIV 100 / 0 -> div_zero pulse in the cycle after start; done never asserted; hi/lo keep the previous values; unit then accepts a new start.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- MULT 0x7FFFFFFF x 0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001; second start asserted at cycle 10 is ignored, and exactly one done is produced.
- Reset at cycle 15 of a MULT -> next cycle: busy=0, hi=lo=0, no done.
- With MD_EARLY_OUT_EN defined, MULT 5 x 0 -> done in the cycle after edge 1.
